// File: rtl/serdes_rst_pkg.sv
// Shared definitions for the SerDes lane reset sequencer: state encoding,
// default cycle counts and the lock-loss counter width.
package serdes_rst_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_GT_RST    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_USR_DLY   = 3'd4,
        S_RUN       = 3'd5,
        S_FAIL      = 3'd6
    } seq_state_t;

    localparam int DEF_PLL_RST_CYC = 16;
    localparam int DEF_LOCK_TO_CYC = 65536;
    localparam int DEF_GT_RST_CYC  = 16;
    localparam int DEF_DONE_TO_CYC = 65536;
    localparam int DEF_USR_DLY_CYC = 8;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_CNT_W       = 17;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/serdes_rst_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by rst_n.
module serdes_rst_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/serdes_rst_seq.sv
// Reset sequencer for one SerDes lane: PLL reset, then GT reset, then user reset.
// Define SERDES_RST_SEQ_LOSS_CNT_EN to enable the lock-loss event counter.
module serdes_rst_seq
    import serdes_rst_pkg::*;
#(
    parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
    parameter int LOCK_TO_CYC = DEF_LOCK_TO_CYC,
    parameter int GT_RST_CYC  = DEF_GT_RST_CYC,
    parameter int DONE_TO_CYC = DEF_DONE_TO_CYC,
    parameter int USR_DLY_CYC = DEF_USR_DLY_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst,
    input  logic                  pll_lock,
    input  logic                  gt_rst_done,
    output logic                  pll_rst,
    output logic                  gt_rst,
    output logic                  usr_rst,
    output logic                  seq_done,
    output logic                  seq_fail,
    output logic [2:0]            seq_state,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    seq_state_t         state, next_state;
    logic [CNT_W-1:0]   timer;
    logic [RETRY_W-1:0] retry, retry_next;
    logic               lock_s, done_s;
    logic               pll_rst_d, gt_rst_d, usr_rst_d;

    serdes_rst_bit_sync u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock),    .q(lock_s));
    serdes_rst_bit_sync u_done_sync (.clk(clk), .rst_n(rst_n), .d(gt_rst_done), .q(done_s));

    always_comb begin
        next_state = state;
        retry_next = retry;
        case (state)
            S_PLL_RST: begin
                if (timer == CNT_W'(PLL_RST_CYC - 1)) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock is tested before the timeout so a simultaneous arrival wins.
                if (lock_s) begin
                    next_state = S_GT_RST;
                end else if (timer == CNT_W'(LOCK_TO_CYC - 1)) begin
                    retry_next = retry + RETRY_W'(1);
                    next_state = (retry == RETRY_W'(MAX_RETRY - 1)) ? S_FAIL : S_PLL_RST;
                end
            end
            S_GT_RST: begin
                if (timer == CNT_W'(GT_RST_CYC - 1)) next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!lock_s) begin
                    next_state = S_PLL_RST;
                end else if (done_s) begin
                    next_state = S_USR_DLY;
                end else if (timer == CNT_W'(DONE_TO_CYC - 1)) begin
                    retry_next = retry + RETRY_W'(1);
                    next_state = (retry == RETRY_W'(MAX_RETRY - 1)) ? S_FAIL : S_PLL_RST;
                end
            end
            S_USR_DLY: begin
                if (!lock_s) begin
                    next_state = S_PLL_RST;
                end else if (timer == CNT_W'(USR_DLY_CYC - 1)) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                retry_next = '0;
                if (!lock_s) begin
                    next_state = S_PLL_RST;
                end else if (!done_s) begin
                    next_state = S_GT_RST;
                end
            end
            S_FAIL: begin
                next_state = S_FAIL;
            end
            default: begin
                next_state = S_PLL_RST;
            end
        endcase
        if (soft_rst) begin
            next_state = S_PLL_RST;
            retry_next = '0;
        end
    end

    // Output levels are decoded from the state being entered so they change with it.
    always_comb begin
        pll_rst_d = (next_state == S_PLL_RST) || (next_state == S_FAIL);
        gt_rst_d  = (next_state == S_PLL_RST) || (next_state == S_WAIT_LOCK) ||
                    (next_state == S_GT_RST)  || (next_state == S_FAIL);
        usr_rst_d = (next_state != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_PLL_RST;
            timer    <= '0;
            retry    <= '0;
            pll_rst  <= 1'b1;
            gt_rst   <= 1'b1;
            usr_rst  <= 1'b1;
            seq_done <= 1'b0;
            seq_fail <= 1'b0;
        end else begin
            state    <= next_state;
            retry    <= retry_next;
            pll_rst  <= pll_rst_d;
            gt_rst   <= gt_rst_d;
            usr_rst  <= usr_rst_d;
            seq_done <= (next_state == S_RUN);
            seq_fail <= (next_state == S_FAIL);
            if ((next_state != state) || soft_rst) begin
                timer <= '0;
            end else if ((state != S_RUN) && (state != S_FAIL)) begin
                timer <= timer + CNT_W'(1);
            end
        end
    end

    assign seq_state = state;

`ifdef SERDES_RST_SEQ_LOSS_CNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    assign loss_evt = (state == S_RUN) && !lock_s && !soft_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (soft_rst) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
